// File: rtl/instr_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// instr_ctrl_pkg : opcodes, FSM state encoding and register-file source codes
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package instr_ctrl_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ALU_LO = 4'h1;
  localparam logic [3:0] OP_ALU_HI = 4'h7;
  localparam logic [3:0] OP_LDI    = 4'h8;
  localparam logic [3:0] OP_LDI2   = 4'h9;
  localparam logic [3:0] OP_JMP    = 4'hA;
  localparam logic [3:0] OP_HALT   = 4'hF;

  localparam logic [1:0] RF_SRC_D1  = 2'b00;
  localparam logic [1:0] RF_SRC_D2  = 2'b01;
  localparam logic [1:0] RF_SRC_ALU = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB1    = 3'd4,
    ST_WB2    = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_sequencer_if.sv
// ----------------------------------------------------------------------------
// instr_sequencer_if : imem, decoder, ALU and register-file handshake bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface instr_sequencer_if #(
  parameter int PC_W = 8
);

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic [31:0]     ir;
  logic [3:0]      opcode;
  logic [7:0]      jmp_tgt;
  logic            alu_start;
  logic            alu_done;
  logic            rf_we;
  logic [1:0]      rf_src;

  modport master (
    output imem_req, imem_addr, ir, alu_start, rf_we, rf_src,
    input  imem_ack, imem_rdata, opcode, jmp_tgt, alu_done
  );

  modport slave (
    input  imem_req, imem_addr, ir, alu_start, rf_we, rf_src,
    output imem_ack, imem_rdata, opcode, jmp_tgt, alu_done
  );

endinterface

`default_nettype wire

// File: rtl/alu_watchdog.sv
// ----------------------------------------------------------------------------
// alu_watchdog : clear/enable cycle counter that flags an ALU timeout
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_watchdog #(
  parameter  int ALU_TMO = 15,
  localparam int CNT_W   = $clog2(ALU_TMO + 1)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clear_i,
  input  wire logic             en_i,
  output logic      [CNT_W-1:0] count_o,
  output logic                  timeout_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(ALU_TMO);

  logic [CNT_W-1:0] count_q, count_d;

  // Saturates at the limit so the count can never wrap back to zero.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign timeout_o = en_i && (count_q == LIMIT);

endmodule

`default_nettype wire

// File: rtl/instr_sequencer.sv
// ----------------------------------------------------------------------------
// instr_sequencer : multi-cycle fetch/decode/execute control FSM
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module instr_sequencer
  import instr_ctrl_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int ALU_TMO = 15
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            start_i,
  instr_sequencer_if.master    bus,
  output logic      [PC_W-1:0] pc_o,
  output logic                 busy_o,
  output logic                 halted_o,
  output logic                 err_o
);

  localparam int CNT_W = $clog2(ALU_TMO + 1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic            err_q, err_d;
  logic [1:0]      rf_src_q, rf_src_d;

  logic             w_wd_clear;
  logic             w_wd_timeout;
  logic [CNT_W-1:0] w_wd_count;
  logic [PC_W-1:0]  w_jmp_pc;

  generate
    if (PC_W > 8) begin : g_tgt_zext
      assign w_jmp_pc = {{(PC_W-8){1'b0}}, bus.jmp_tgt};
    end else begin : g_tgt_trunc
      assign w_jmp_pc = bus.jmp_tgt[PC_W-1:0];
    end
  endgenerate

  alu_watchdog #(
    .ALU_TMO (ALU_TMO)
  ) u_alu_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (w_wd_clear),
    .en_i      (state_q == ST_EXEC),
    .count_o   (w_wd_count),
    .timeout_o (w_wd_timeout)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    err_d      = err_q;
    rf_src_d   = rf_src_q;
    w_wd_clear = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start_i) begin
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (is_alu_op(bus.opcode)) begin
          w_wd_clear = 1'b1;
          state_d    = ST_EXEC;
        end else begin
          case (bus.opcode)
            OP_NOP: state_d = ST_FETCH;
            OP_LDI, OP_LDI2: begin
              rf_src_d = RF_SRC_D1;
              state_d  = ST_WB1;
            end
            OP_JMP: begin
              pc_d    = w_jmp_pc;
              state_d = ST_FETCH;
            end
            OP_HALT: state_d = ST_HALT;
            // Illegal opcodes flag the error and fall through as a NOP.
            default: begin
              err_d   = 1'b1;
              state_d = ST_FETCH;
            end
          endcase
        end
      end

      // A result arriving on the timeout cycle still takes priority.
      ST_EXEC: begin
        if (bus.alu_done) begin
          rf_src_d = RF_SRC_ALU;
          state_d  = ST_WB1;
        end else if (w_wd_timeout) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end
      end

      ST_WB1: begin
        if (bus.opcode == OP_LDI2) begin
          rf_src_d = RF_SRC_D2;
          state_d  = ST_WB2;
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_WB2: state_d = ST_FETCH;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      err_q    <= 1'b0;
      rf_src_q <= RF_SRC_D1;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      err_q    <= err_d;
      rf_src_q <= rf_src_d;
    end
  end

  assign bus.imem_req  = (state_q == ST_FETCH);
  assign bus.imem_addr = (state_q == ST_FETCH) ? pc_q : '0;
  assign bus.ir        = ir_q;
  assign bus.alu_start = (state_q == ST_EXEC) && (w_wd_count == '0);
  assign bus.rf_we     = (state_q == ST_WB1) || (state_q == ST_WB2);
  assign bus.rf_src    = rf_src_q;

  assign pc_o     = pc_q;
  assign busy_o   = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted_o = (state_q == ST_HALT);
  assign err_o    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
// ----------------------------------------------------------------------------
// tb_instr_sequencer : directed programs checked against an instruction-level model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_instr_sequencer;

  localparam int PC_W    = 8;
  localparam int ALU_TMO = 15;

  localparam int A_NONE = 0, A_EXEC = 1, A_HALT = 2, A_JMP = 3, A_ERR = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_EXEC = 2, M_HALT = 3;

  typedef struct {
    bit         we;
    logic [1:0] src;
    int         act;
  } cyc_t;

  logic            clk   = 1'b0;
  logic            rst   = 1'b1;
  logic            start = 1'b0;
  logic [PC_W-1:0] pc_o;
  logic            busy_o, halted_o, err_o;

  instr_sequencer_if #(.PC_W(PC_W)) bus();

  instr_sequencer #(
    .PC_W    (PC_W),
    .ALU_TMO (ALU_TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .bus      (bus),
    .pc_o     (pc_o),
    .busy_o   (busy_o),
    .halted_o (halted_o),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;

  int          n_vec = 0, n_err = 0;
  logic [31:0] mem [256];
  int          ack_dly = 0, alu_lat = -1, wcnt = 0, acnt = -1;
  bit          stray = 1'b0, r_ack = 1'b0, r_done = 1'b0;
  logic [31:0] r_data = 32'hDEAD_BEEF;
  int          n_we = 0, n_start = 0;

  assign bus.imem_ack   = r_ack | stray;
  assign bus.imem_rdata = r_data;
  assign bus.alu_done   = r_done | stray;
  assign bus.opcode     = bus.ir[3:0];
  assign bus.jmp_tgt    = bus.ir[11:4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory and ALU responders, driven just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (bus.imem_req) begin
      if (wcnt >= ack_dly) begin
        r_ack  = 1'b1;
        r_data = mem[bus.imem_addr];
        wcnt   = 0;
      end else begin
        r_ack  = 1'b0;
        r_data = 32'hDEAD_BEEF;
        wcnt++;
      end
    end else begin
      r_ack  = 1'b0;
      r_data = 32'hDEAD_BEEF;
      wcnt   = 0;
    end
    if (bus.alu_start) acnt = 0;
    else if (acnt >= 0) acnt++;
    r_done = (alu_lat >= 0) && (acnt == alu_lat);
    if (r_done) acnt = -1;
  end

  initial forever begin
    @(negedge clk);
    if (bus.rf_we)     n_we++;
    if (bus.alu_start) n_start++;
  end

  // Reference model: each fetched word expands into the cycles it must occupy.
  bit          m_valid = 1'b0;
  int          m_mode  = M_IDLE;
  int          m_k     = 0;
  logic [7:0]  m_pc    = '0;
  logic [31:0] m_ir    = '0;
  bit          m_err   = 1'b0;
  logic [1:0]  m_src   = '0;
  cyc_t        m_q[$];

  function automatic cyc_t mk(input bit we, input logic [1:0] src, input int act);
    cyc_t c;
    c.we  = we;
    c.src = src;
    c.act = act;
    return c;
  endfunction

  function automatic void push_instr(input logic [3:0] op);
    if (op >= 4'h1 && op <= 4'h7) m_q.push_back(mk(1'b0, 2'b00, A_EXEC));
    else if (op == 4'h0) m_q.push_back(mk(1'b0, 2'b00, A_NONE));
    else if (op == 4'h8) begin
      m_q.push_back(mk(1'b0, 2'b00, A_NONE));
      m_q.push_back(mk(1'b1, 2'b00, A_NONE));
    end else if (op == 4'h9) begin
      m_q.push_back(mk(1'b0, 2'b00, A_NONE));
      m_q.push_back(mk(1'b1, 2'b00, A_NONE));
      m_q.push_back(mk(1'b1, 2'b01, A_NONE));
    end else if (op == 4'hA) m_q.push_back(mk(1'b0, 2'b00, A_JMP));
    else if (op == 4'hF) m_q.push_back(mk(1'b0, 2'b00, A_HALT));
    else m_q.push_back(mk(1'b0, 2'b00, A_ERR));
  endfunction

  initial forever begin : p_cmp
    cyc_t       c;
    bit         e_req, e_we, e_st, e_busy, e_halt;
    logic [7:0] e_addr;
    @(negedge clk);
    e_req = 1'b0; e_we = 1'b0; e_st = 1'b0; e_busy = 1'b0; e_halt = 1'b0; e_addr = '0;
    if (m_valid) begin
      case (m_mode)
        M_RUN: begin
          e_busy = 1'b1;
          if (m_q.size() == 0) begin
            e_req  = 1'b1;
            e_addr = m_pc;
          end else begin
            c    = m_q[0];
            e_we = c.we;
            if (c.we) m_src = c.src;
          end
        end
        M_EXEC: begin
          e_busy = 1'b1;
          e_st   = (m_k == 0);
        end
        M_HALT:  e_halt = 1'b1;
        default: ;
      endcase
      check("imem_req",  {31'b0, bus.imem_req},  {31'b0, e_req});
      check("imem_addr", {24'b0, bus.imem_addr}, {24'b0, e_addr});
      check("rf_we",     {31'b0, bus.rf_we},     {31'b0, e_we});
      check("alu_start", {31'b0, bus.alu_start}, {31'b0, e_st});
      check("busy",      {31'b0, busy_o},        {31'b0, e_busy});
      check("halted",    {31'b0, halted_o},      {31'b0, e_halt});
      check("err",       {31'b0, err_o},         {31'b0, m_err});
      check("pc",        {24'b0, pc_o},          {24'b0, m_pc});
      check("ir",        bus.ir,                 m_ir);
      check("rf_src",    {30'b0, bus.rf_src},    {30'b0, m_src});
    end
    if (rst) begin
      m_valid = 1'b1; m_mode = M_IDLE; m_k = 0; m_pc = '0; m_ir = '0;
      m_err = 1'b0; m_src = '0; m_q.delete();
    end else if (m_valid) begin
      case (m_mode)
        M_IDLE, M_HALT: if (start) m_mode = M_RUN;
        M_RUN: begin
          if (m_q.size() == 0) begin
            if (bus.imem_ack) begin
              m_pc = m_pc + 8'd1;
              m_ir = bus.imem_rdata;
              push_instr(m_ir[3:0]);
            end
          end else begin
            c = m_q.pop_front();
            if (c.act == A_EXEC) begin m_mode = M_EXEC; m_k = 0; end
            else if (c.act == A_HALT) m_mode = M_HALT;
            else if (c.act == A_JMP) m_pc = m_ir[11:4];
            else if (c.act == A_ERR) m_err = 1'b1;
          end
        end
        M_EXEC: begin
          if (bus.alu_done) begin
            m_mode = M_RUN;
            m_q.push_back(mk(1'b1, 2'b10, A_NONE));
          end else if (m_k == ALU_TMO) begin
            m_err  = 1'b1;
            m_mode = M_HALT;
          end else begin
            m_k++;
          end
        end
        default: ;
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_halt(input string name, input int budget);
    int i = 0;
    while (!halted_o && i < budget) begin
      tick(1);
      i++;
    end
    check(name, {31'b0, halted_o}, 32'd1);
  endtask

  task automatic wait_we(input string name, input int budget);
    int i = 0;
    while (!bus.rf_we && i < budget) begin
      tick(1);
      i++;
    end
    check(name, {31'b0, bus.rf_we}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_000F;
    tick(3);
    check("reset_pc",   {24'b0, pc_o},   32'd0);
    check("reset_busy", {31'b0, busy_o}, 32'd0);
    check("reset_ir",   bus.ir,          32'd0);
    rst = 1'b0;

    // LDI, NOP, HALT / LDI2, HALT / ALU, HALT / ALU with no result
    mem[0] = 32'h0005_A038; mem[1] = 32'h0000_0000; mem[2] = 32'h0000_000F;
    mem[3] = 32'h1234_5679; mem[4] = 32'h0000_000F;
    mem[5] = 32'h0000_0011; mem[6] = 32'h0000_000F;
    mem[7] = 32'h0000_0002;

    stray = 1'b1;
    tick(2);
    stray = 1'b0;
    check("stray_idle_busy", {31'b0, busy_o}, 32'd0);

    pulse_start();
    wait_we("ldi_we", 10);
    check("ldi_src", {30'b0, bus.rf_src}, 32'd0);
    check("ldi_pc",  {24'b0, pc_o},       32'd1);
    wait_halt("halt1", 20);
    check("halt1_pc", {24'b0, pc_o}, 32'd3);

    pulse_start();
    check("resume_req",  {31'b0, bus.imem_req},  32'd1);
    check("resume_addr", {24'b0, bus.imem_addr}, 32'd3);
    wait_we("ldi2_we1", 10);
    check("ldi2_src1", {30'b0, bus.rf_src}, 32'd0);
    tick(1);
    check("ldi2_we2",  {31'b0, bus.rf_we},  32'd1);
    check("ldi2_src2", {30'b0, bus.rf_src}, 32'd1);
    tick(1);
    check("ldi2_we_off", {31'b0, bus.rf_we},    32'd0);
    check("ldi2_refetch", {31'b0, bus.imem_req}, 32'd1);
    wait_halt("halt2", 20);

    alu_lat = 3;
    n_start = 0;
    pulse_start();
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_halt("halt_alu", 40);
    check("alu_err",    {31'b0, err_o},      32'd0);
    check("alu_starts", n_start,             32'd1);
    check("alu_src",    {30'b0, bus.rf_src}, 32'd2);
    check("alu_pc",     {24'b0, pc_o},       32'd7);

    alu_lat = -1;
    pulse_start();
    wait_halt("halt_tmo", 60);
    check("tmo_err", {31'b0, err_o}, 32'd1);
    check("tmo_pc",  {24'b0, pc_o},  32'd8);

    // Result on the timeout cycle itself must be accepted.
    do_reset();
    check("rst_clears_err", {31'b0, err_o}, 32'd0);
    mem[0] = 32'h0000_0003; mem[1] = 32'h0000_000F;
    alu_lat = ALU_TMO;
    pulse_start();
    wait_halt("halt_edge", 60);
    check("edge_err", {31'b0, err_o},      32'd0);
    check("edge_src", {30'b0, bus.rf_src}, 32'd2);
    alu_lat = -1;

    // Jumps, an illegal opcode, and pc wrap at 0xFF.
    do_reset();
    mem[0]    = 32'h0000_010A; mem[8'h10] = 32'h0000_040A;
    mem[8'h40] = 32'h0000_000B; mem[8'h41] = 32'h0000_0FFA;
    mem[8'hFF] = 32'h0000_000F;
    pulse_start();
    wait_halt("halt_jmp", 60);
    check("jmp_err", {31'b0, err_o}, 32'd1);
    check("wrap_pc", {24'b0, pc_o},  32'd0);

    // Slow fetch, then reset in the middle of an ALU wait.
    do_reset();
    mem[0]  = 32'h0000_0001;
    ack_dly = 5;
    n_we    = 0;
    pulse_start();
    begin
      int i = 0;
      while (!bus.alu_start && i < 20) begin
        tick(1);
        i++;
      end
      check("slow_alu_start", {31'b0, bus.alu_start}, 32'd1);
    end
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("abort_req",    {31'b0, bus.imem_req},  32'd0);
    check("abort_addr",   {24'b0, bus.imem_addr}, 32'd0);
    check("abort_we",     {31'b0, bus.rf_we},     32'd0);
    check("abort_start",  {31'b0, bus.alu_start}, 32'd0);
    check("abort_busy",   {31'b0, busy_o},        32'd0);
    check("abort_halted", {31'b0, halted_o},      32'd0);
    check("abort_err",    {31'b0, err_o},         32'd0);
    check("abort_pc",     {24'b0, pc_o},          32'd0);
    check("abort_ir",     bus.ir,                 32'd0);
    check("abort_src",    {30'b0, bus.rf_src},    32'd0);
    tick(10);
    check("abort_no_write", n_we, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule

`default_nettype wire
